// File: rtl/paint_pkg.sv
// Shared constants for the multi-channel run painter: default widths and
// the standard 4:4:4 colours used by callers and tests.
package paint_pkg;

    localparam int DEF_NCH  = 4;
    localparam int DEF_CW   = 12;
    localparam int DEF_LENW = 10;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_GREEN = 12'h0F0;
    localparam logic [11:0] COL_RED   = 12'hF00;
    localparam logic [11:0] COL_BLUE  = 12'h00F;

endpackage

// File: rtl/paint_channel.sv
// One print channel: a down-counter that turns a trigger into a run of
// 'len' busy cycles. IDLE is cnt==0, RUN is cnt!=0; busy exposes that state.
module paint_channel
    import paint_pkg::*;
#(
    parameter int LENW   = DEF_LENW,
    parameter int RETRIG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            print,
    input  logic [LENW-1:0] len,
    output logic            busy
);

    logic [LENW-1:0] r_cnt;
    logic            w_accept;

    // With RETRIG a trigger always reloads; a reload with len==0 aborts the run.
    assign w_accept = print && ((r_cnt == '0) || (RETRIG != 0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign busy = (r_cnt != '0);

endmodule

// File: rtl/paint_multi.sv
// Multi-channel run painter: per-channel run counters, a lowest-index-wins
// priority select, and one output register stage feeding the pixel mux.
module paint_multi
    import paint_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int CW     = DEF_CW,
    parameter int LENW   = DEF_LENW,
    parameter int RETRIG = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NCH-1:0]                       print,
    input  logic [LENW-1:0]                      len,
    input  logic [NCH*CW-1:0]                    colour_cfg,
    input  logic [CW-1:0]                        bg_colour,
    output logic [CW-1:0]                        colour,
    output logic                                 stat,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] chan,
    output logic [NCH-1:0]                       busy
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] w_busy;
    logic [CHW-1:0] w_chan_next;
    logic [CW-1:0]  w_colour_next;
    logic [CW-1:0]  r_colour;
    logic           r_stat;
    logic [CHW-1:0] r_chan;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        paint_channel #(
            .LENW   (LENW),
            .RETRIG (RETRIG)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .print (print[g]),
            .len   (len),
            .busy  (w_busy[g])
        );
    end

    // Scan from the top so the lowest busy index is the last (winning) write;
    // higher runs keep counting underneath and reappear when lower ones end.
    always_comb begin
        w_chan_next   = '0;
        w_colour_next = bg_colour;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_busy[i]) begin
                w_chan_next   = CHW'(i);
                w_colour_next = colour_cfg[i*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_colour <= '0;
            r_stat   <= 1'b0;
            r_chan   <= '0;
        end else begin
            r_colour <= w_colour_next;
            r_stat   <= |w_busy;
            r_chan   <= w_chan_next;
        end
    end

    assign colour = r_colour;
    assign stat   = r_stat;
    assign chan   = r_chan;
    assign busy   = w_busy;

endmodule
